// File: rtl/sum_display_driver.sv
// Converts an 8-bit sum to 3-digit BCD (double-dabble) and scans it onto a 4-digit
// multiplexed 7-segment display. Define SUM_LEADING_BLANK_EN to blank leading zeros.
module sum_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  val_in,
    input  logic        load,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BIN_W = 8;
    localparam int unsigned BCD_W = 12;
    localparam int unsigned DD_W  = BCD_W + BIN_W;

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state, state_nxt;
    logic [DD_W-1:0]    dd, dd_nxt, dd_step;
    logic [2:0]         iter, iter_nxt;
    logic               busy_nxt;
    logic [BCD_W-1:0]   bcd_out_nxt;

    logic [CNT_W-1:0]   refresh_cnt;
    logic [1:0]         digit_idx;
    logic [3:0]         digit;
    logic               blank;
    logic [3:0]         an_nxt;
    logic [6:0]         seg_nxt;

    // One double-dabble step over {hundreds, tens, ones, binary}: adjust, then shift
    function automatic logic [DD_W-1:0] dabble(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            if (t[BIN_W+4*i +: 4] >= 4'd5)
                t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
        end
        return {t[DD_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dd      <= '0;
            iter    <= '0;
            busy    <= 1'b0;
            bcd_out <= '0;
        end else begin
            state   <= state_nxt;
            dd      <= dd_nxt;
            iter    <= iter_nxt;
            busy    <= busy_nxt;
            bcd_out <= bcd_out_nxt;
        end
    end

    // Conversion FSM; the eighth step's result is written straight to bcd_out
    always_comb begin
        state_nxt   = state;
        dd_nxt      = dd;
        iter_nxt    = iter;
        busy_nxt    = busy;
        bcd_out_nxt = bcd_out;
        dd_step     = dabble(dd);
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = CONV;
                    dd_nxt    = {BCD_W'(0), val_in};
                    iter_nxt  = '0;
                    busy_nxt  = 1'b1;
                end
            end
            CONV: begin
                dd_nxt   = dd_step;
                iter_nxt = iter + 3'd1;
                if (iter == 3'd7) begin
                    state_nxt   = IDLE;
                    busy_nxt    = 1'b0;
                    bcd_out_nxt = dd_step[DD_W-1:BIN_W];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        digit  = 4'd0;
        blank  = 1'b0;
        an_nxt = 4'b1111;
        case (digit_idx)
            2'd0: begin
                digit  = bcd_out[3:0];
                an_nxt = 4'b1110;
            end
            2'd1: begin
                digit  = bcd_out[7:4];
                an_nxt = 4'b1101;
`ifdef SUM_LEADING_BLANK_EN
                blank  = (bcd_out[11:4] == 8'd0);
`endif
            end
            2'd2: begin
                digit  = bcd_out[11:8];
                an_nxt = 4'b1011;
`ifdef SUM_LEADING_BLANK_EN
                blank  = (bcd_out[11:8] == 4'd0);
`endif
            end
            default: blank = 1'b1;
        endcase
        seg_nxt = blank ? 7'b1111111 : seg_decode(digit);
        if (blank)
            an_nxt = 4'b1111;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

    assign dp = 1'b1;

endmodule

// File: doc/sum_display_driver.md
SUM_DISPLAY_DRIVER -- requirements
Module: sum_display_driver

Interface
REQ-001 SHALL provide parameter: REFRESH_DIV, 100000, clock cycles per displayed digit (legal range 2 to 2^20).
REQ-002 SHALL provide port: clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: val_in  input  8  unsigned binary sum from the 4-bit adder stage (S1_f), 0..255.
REQ-005 SHALL provide port: load  input  1  request to capture val_in; sampled on rising edge.
REQ-006 SHALL provide port: busy  output  1  high while a conversion is in progress.
REQ-007 SHALL provide port: bcd_out  output  12  {hundreds, tens, ones} BCD of last completed conversion.
REQ-008 SHALL provide port: an  output  4  digit anodes, active-low; an[0] ones, an[1] tens, an[2] hundreds, an[3] unused.
REQ-009 SHALL provide port: seg  output  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}.
REQ-010 SHALL provide port: dp  output  1  decimal point, active-low, constant 1.

Function
REQ-011 Conversion FSM SHALL have states IDLE and CONV.
REQ-012 In IDLE with load=1 at edge N: SHALL capture val_in into a shift register, clear the BCD scratch register and iteration count, enter CONV, and drive busy=1.
REQ-013 In CONV: SHALL perform one double-dabble iteration per clock (add 3 to every BCD nibble >= 5, then shift left 1 bit), exactly 8 iterations at edges N+1..N+8.
REQ-014 At edge N+8: SHALL write the result to bcd_out, return to IDLE, and drive busy=0; bcd_out SHALL NOT change at any other time except reset.
REQ-015 load while in CONV (including edge N+8) SHALL be ignored and not queued; the earliest new capture is edge N+9.
REQ-016 Changes on val_in after capture SHALL NOT affect the conversion in progress.
REQ-017 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, the digit index SHALL advance 0->1->2->0.
REQ-018 an and seg SHALL be registered, reflecting the digit index and bcd_out one clock later.
REQ-019 Exactly one of an[2:0] SHALL be low for a displayed digit; an[3] SHALL always be 1.
REQ-020 seg SHALL decode BCD 0-9 to standard patterns (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
REQ-021 Refresh scanning SHALL continue unaffected during conversion, displaying the previous bcd_out.

Reset
REQ-022 rst_n=0 SHALL asynchronously force: state IDLE, busy=0, bcd_out=0, refresh counter=0, digit index=0, an=1111, seg=1111111, dp=1.
REQ-023 Reset during CONV SHALL abort the conversion; bcd_out SHALL stay 0 after release until a new conversion completes.
REQ-024 After rst_n deasserts, the first non-reset edge SHALL resume normal operation, with no extra synchronisation cycles.

Configuration
REQ-025 Macro SUM_LEADING_BLANK_EN SHALL control leading-zero blanking.
REQ-026 With SUM_LEADING_BLANK_EN defined: hundreds SHALL blank when 0; tens SHALL blank when hundreds and tens are both 0; ones SHALL never blank. A blanked slot SHALL drive an=1111 and seg=1111111 for its full period.
REQ-027 Without SUM_LEADING_BLANK_EN: all three digits SHALL always display, including leading zeros.

Verification (REFRESH_DIV=4)
REQ-028 Reset then release: an=1111 and seg=1111111 during reset; busy=0 and bcd_out=000 after release.
REQ-029 val_in=8'd30 (max 15+15), load pulse at edge N: busy=1 for edges N..N+7; at edge N+8 bcd_out=0x030 and busy=0.
REQ-030 val_in=8'd255, load held high for 20 cycles: conversions complete every 9 cycles; bcd_out=0x255 after the first completion.
REQ-031 Load pulse during CONV with a different val_in: ignored, and the first result is unchanged.
REQ-032 bcd_out=0x007, scan one full cycle: without the macro, an cycles 1110/1101/1011 with seg 1111000/1000000/1000000; with the macro, the tens and hundreds slots show an=1111.
REQ-033 rst_n pulled low at edge N+4 of a conversion of 8'd200: bcd_out=000 and busy=0 immediately; no late update follows.
